bmc_flt_retry_ctrl: RTL
=======================

# bmc_flt_retry_ctrl

Fault-recovery scheduler for the BMC power sequencer. Watches the sequencer's fault and power-good outputs and decides when to release the sequencer from its fault state. Release is a one-cycle go-out-of-fault pulse, issued after an exponential back-off. After a bounded number of retries the block latches a lockout until firmware or PFR clears it. Sits between the BMC sequencer and the master sequencer / PFR mailbox in the core CPLD.

## Interface
- MAX_RETRY, 3: release attempts allowed before lockout (1..15).
- BACKOFF_MS, 100: base back-off in ms. Attempt k (k = 0..MAX_RETRY-1) waits BACKOFF_MS << k.
- STABLE_MS, 1000: continuous power-good time that clears the retry count.
- TMR_BITS, 16: ms timer width. Must hold max(BACKOFF_MS << (MAX_RETRY-1), STABLE_MS).

Ports:
- iClk  in  1  system clock.
- iRst_n  in  1  reset, asynchronous, active-low.
- i1mSCE  in  1  1 ms clock enable, one iClk cycle wide.
- iBmcPwrFlt  in  1  BMC VR fault from the sequencer (level).
- iBmcPwrgd  in  1  all BMC VRs good from the sequencer (level).
- iClrLockout  in  1  lockout clear request (pulse, mailbox/PFR).
- oGoOutFltSt  out  1  one-cycle pulse that releases the sequencer from its fault state.
- oRetryActive  out  1  high in WAIT_BACKOFF, PULSE and WAIT_CLR.
- oLockout  out  1  retries exhausted.
- oRetryCnt  out  4  attempts since the last stable window or clear.
- oFltCnt  out  8  total faults since reset, saturating at 255.

## Operation
- All outputs are registered. Reset values: state MONITOR, all outputs 0, timers 0.
- **MONITOR**
  - iBmcPwrFlt=1 and oRetryCnt==MAX_RETRY: go to LOCKOUT.
  - iBmcPwrFlt=1 otherwise: load the timer with BACKOFF_MS << oRetryCnt, go to WAIT_BACKOFF.
  - Either fault exit increments oFltCnt, saturating.
  - Stable counter:
    - Runs only while iBmcPwrgd=1 and oRetryCnt>0; decrements on i1mSCE.
    - Reloads to STABLE_MS whenever iBmcPwrgd=0.
    - On reaching 0, oRetryCnt clears to 0.
- **WAIT_BACKOFF**: timer decrements on i1mSCE. At 0, go to PULSE. iBmcPwrFlt dropping here does not abort the sequence; the pulse is still issued.
- **PULSE**: oGoOutFltSt=1 for exactly one cycle, oRetryCnt increments, go to WAIT_CLR.
- **WAIT_CLR**: wait for iBmcPwrFlt=0, then go to MONITOR and reload the stable counter. No timeout.
- **LOCKOUT**
  - oLockout=1. No pulses are issued.
  - iClrLockout=1 clears oRetryCnt and oLockout, then goes to MONITOR.
  - If the fault is still present, MONITOR starts a fresh back-off from k=0.
- iClrLockout is ignored outside LOCKOUT.
- Unused state encodings recover to MONITOR.

## Timing
- Fault to pulse: the fault is seen in MONITOR at cycle t and WAIT_BACKOFF is entered at t+1. The pulse follows N i1mSCE ticks later, plus 1 cycle, where N = BACKOFF_MS << k. Wall time is in (N-1, N] ms.
- The back-off timer is loaded on entry. A tick in the entry cycle is not counted.
- oGoOutFltSt is never asserted on two consecutive cycles. Minimum spacing between pulses is one back-off.
- Simultaneous events:
  - Fault rising in the same cycle the stable counter expires: the fault wins and oRetryCnt is not cleared before it is compared with MAX_RETRY.
  - iClrLockout together with iBmcPwrFlt in LOCKOUT: the clear is taken, and the fault is handled next cycle from MONITOR.
- Reset asserted mid-sequence: everything returns immediately to reset values. A pending pulse is dropped; oFltCnt is cleared.
- oRetryCnt, oFltCnt and oLockout are updated in the same cycle as the state transition that causes them.

## Structure
- Package bmc_flt_pkg holds:
  - the state encoding (MONITOR, WAIT_BACKOFF, PULSE, WAIT_CLR, LOCKOUT; 3-bit);
  - the retry and fault counter widths;
  - the fault-counter saturation constant.
- One sub-module, ms_down_timer: load value, load strobe, i1mSCE enable, zero flag; TMR_BITS wide.
- Two instances: back-off and stable window. The FSM and counters live in the top level.

## Test plan
All scenarios use MAX_RETRY=3, BACKOFF_MS=2, STABLE_MS=5, and a 1 ms tick every 10 clocks.
- Reset, then hold all inputs 0 for 50 clocks -> all outputs 0, state MONITOR.
- Single fault at k=0 -> exactly one oGoOutFltSt pulse 2 ticks (+1 cycle) after entry; oRetryCnt=1, oFltCnt=1. Drop the fault -> MONITOR. Pwrgd high for 5 ticks -> oRetryCnt=0.
- Three faults back-to-back with no pwrgd -> pulses after 2, 4 and 8 ticks. A fourth fault -> oLockout=1, no pulse; oFltCnt=4.
- In LOCKOUT with the fault held, pulse iClrLockout -> oLockout=0, oRetryCnt=0, new pulse after 2 ticks. iClrLockout in MONITOR -> no effect.
- Pwrgd high for 4 ticks, drops for 1 cycle, then high again -> the stable window restarts. Fault in the cycle the window expires -> oRetryCnt not cleared before the compare.
- Reset asserted during WAIT_BACKOFF -> no pulse, all outputs 0. 300 faults -> oFltCnt saturates at 255.

Source files
------------

// File: rtl/bmc_flt_pkg.sv
// rtl/bmc_flt_pkg.sv - shared types and constants for the BMC fault-retry scheduler
package bmc_flt_pkg;

  // Scheduler states; the 3-bit encoding leaves three unused codes that recover to MONITOR.
  typedef enum logic [2:0] {
    ST_MONITOR      = 3'd0,
    ST_WAIT_BACKOFF = 3'd1,
    ST_PULSE        = 3'd2,
    ST_WAIT_CLR     = 3'd3,
    ST_LOCKOUT      = 3'd4
  } fltState_e;

  localparam int RETRY_CNT_W = 4;
  localparam int FLT_CNT_W   = 8;

  // Total-fault counter holds here instead of wrapping.
  localparam logic [FLT_CNT_W-1:0] FLT_CNT_SAT = 8'd255;

endpackage

// File: rtl/ms_down_timer.sv
// rtl/ms_down_timer.sv - loadable millisecond down-counter with zero flag
module ms_down_timer #(
  parameter int TMR_BITS = 16
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic                iLoad,
  input  logic [TMR_BITS-1:0] iLoadVal,
  input  logic                iEn,
  output logic                oZero
);

  logic [TMR_BITS-1:0] countQ;

  // Load wins over a same-cycle tick, so the tick in the load cycle is never counted.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      countQ <= '0;
    end else if (iLoad) begin
      countQ <= iLoadVal;
    end else if (iEn && (countQ != '0)) begin
      countQ <= countQ - TMR_BITS'(1);
    end
  end

  assign oZero = (countQ == '0);

endmodule

// File: rtl/bmc_flt_retry_ctrl.sv
// rtl/bmc_flt_retry_ctrl.sv - fault-recovery scheduler with exponential back-off and lockout
import bmc_flt_pkg::*;

module bmc_flt_retry_ctrl #(
  parameter int MAX_RETRY  = 3,
  parameter int BACKOFF_MS = 100,
  parameter int STABLE_MS  = 1000,
  parameter int TMR_BITS   = 16
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  input  logic                   i1mSCE,
  input  logic                   iBmcPwrFlt,
  input  logic                   iBmcPwrgd,
  input  logic                   iClrLockout,
  output logic                   oGoOutFltSt,
  output logic                   oRetryActive,
  output logic                   oLockout,
  output logic [RETRY_CNT_W-1:0] oRetryCnt,
  output logic [FLT_CNT_W-1:0]   oFltCnt
);

  localparam logic [RETRY_CNT_W-1:0] MAX_RETRY_C = RETRY_CNT_W'(MAX_RETRY);
  localparam logic [TMR_BITS-1:0]    BACKOFF_C   = TMR_BITS'(BACKOFF_MS);
  localparam logic [TMR_BITS-1:0]    STABLE_C    = TMR_BITS'(STABLE_MS);

  fltState_e           stateQ;
  logic                faultExit;
  logic                backoffLoad;
  logic                backoffRun;
  logic                backoffZero;
  logic [TMR_BITS-1:0] backoffVal;
  logic                stableLoad;
  logic                stableRun;
  logic                stableZero;

  // A fault seen in MONITOR either starts a back-off or, with retries used up, locks out.
  assign faultExit   = (stateQ == ST_MONITOR) && iBmcPwrFlt;
  assign backoffLoad = faultExit && (oRetryCnt != MAX_RETRY_C);
  assign backoffVal  = BACKOFF_C << oRetryCnt;
  assign backoffRun  = i1mSCE && (stateQ == ST_WAIT_BACKOFF);

  // Stable window restarts on any power-good drop and on every return to MONITOR.
  assign stableLoad  = !iBmcPwrgd || ((stateQ == ST_WAIT_CLR) && !iBmcPwrFlt);
  assign stableRun   = i1mSCE && iBmcPwrgd && (stateQ == ST_MONITOR) && (oRetryCnt != '0);

  ms_down_timer #(.TMR_BITS(TMR_BITS)) uBackoffTmr (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iLoad    (backoffLoad),
    .iLoadVal (backoffVal),
    .iEn      (backoffRun),
    .oZero    (backoffZero)
  );

  ms_down_timer #(.TMR_BITS(TMR_BITS)) uStableTmr (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iLoad    (stableLoad),
    .iLoadVal (STABLE_C),
    .iEn      (stableRun),
    .oZero    (stableZero)
  );

  // Scheduler FSM; every output is registered and changes on the edge of the transition that causes it.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stateQ       <= ST_MONITOR;
      oGoOutFltSt  <= 1'b0;
      oRetryActive <= 1'b0;
      oLockout     <= 1'b0;
      oRetryCnt    <= '0;
      oFltCnt      <= '0;
    end else begin
      oGoOutFltSt <= 1'b0;
      case (stateQ)
        ST_MONITOR: begin
          if (iBmcPwrFlt) begin
            // Fault beats a same-cycle window expiry: the compare uses the uncleared count.
            if (oFltCnt != FLT_CNT_SAT) begin
              oFltCnt <= oFltCnt + FLT_CNT_W'(1);
            end
            if (oRetryCnt == MAX_RETRY_C) begin
              stateQ       <= ST_LOCKOUT;
              oLockout     <= 1'b1;
              oRetryActive <= 1'b0;
            end else begin
              stateQ       <= ST_WAIT_BACKOFF;
              oRetryActive <= 1'b1;
            end
          end else if (stableZero && (oRetryCnt != '0)) begin
            oRetryCnt <= '0;
          end
        end
        ST_WAIT_BACKOFF: begin
          // Fault dropping here does not abort; the release pulse is still issued.
          if (backoffZero) begin
            stateQ      <= ST_PULSE;
            oGoOutFltSt <= 1'b1;
          end
        end
        ST_PULSE: begin
          stateQ    <= ST_WAIT_CLR;
          oRetryCnt <= oRetryCnt + RETRY_CNT_W'(1);
        end
        ST_WAIT_CLR: begin
          if (!iBmcPwrFlt) begin
            stateQ       <= ST_MONITOR;
            oRetryActive <= 1'b0;
          end
        end
        ST_LOCKOUT: begin
          if (iClrLockout) begin
            stateQ    <= ST_MONITOR;
            oLockout  <= 1'b0;
            oRetryCnt <= '0;
          end
        end
        default: begin
          stateQ       <= ST_MONITOR;
          oRetryActive <= 1'b0;
          oLockout     <= 1'b0;
        end
      endcase
    end
  end

endmodule
